// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: decode request / result bundle for the EX-front-end ALU-control stage.
//   slave  modport: the sequencer (consumes the request, drives status and result)
//   master modport: the upstream control stage / hazard unit side
// Signals:
//   in_valid, alu_op[1:0], funct[5:0], flush : request side (master -> slave)
//   in_ready, out_valid, alu_ctrl[3:0], multicycle, busy, illegal : status/result (slave -> master)
interface alu_op_sequencer_if;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] alu_op;
  logic [5:0] funct;
  logic       flush;
  logic       out_valid;
  logic [3:0] alu_ctrl;
  logic       multicycle;
  logic       busy;
  logic       illegal;

  modport slave (
    input  in_valid, alu_op, funct, flush,
    output in_ready, out_valid, alu_ctrl, multicycle, busy, illegal
  );

  modport master (
    output in_valid, alu_op, funct, flush,
    input  in_ready, out_valid, alu_ctrl, multicycle, busy, illegal
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: registered ALU-control decode with multi-cycle (mul/div) latency tracking.
// Ports:
//   i_clk    : clock, all state updates on the rising edge
//   i_reset  : synchronous active-high reset (priority over flush)
//   bus      : alu_op_sequencer_if.slave (request handshake, flush, result and status)
// Parameters:
//   MUL_CYCLES / DIV_CYCLES : accept-to-out_valid latency of mul / div (>= 2)
//   CNT_W                   : latency counter width, 2^CNT_W-1 >= max latency
// Build option:
//   ALU_SEQ_ILLEGAL_TRAP_EN : when defined, undefined R-type funct sets the illegal flag;
//                             otherwise illegal is tied 0 and such funct decodes to 0000 silently.
module alu_op_sequencer #(
  parameter int unsigned MUL_CYCLES = 3,
  parameter int unsigned DIV_CYCLES = 8,
  parameter int unsigned CNT_W      = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  alu_op_sequencer_if.slave     bus
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_MULTI = 1'b1;

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_ctrl;
  logic             r_out_valid;
  logic             r_multi;
  logic             r_illegal;

  logic [3:0]       w_ctrl;
  logic             w_multi;
  logic             w_undef;
  logic [CNT_W-1:0] w_load;
  logic             w_busy;
  logic             w_accept;
  logic             w_illegal_set;

  // Combinational decode of the presented request.
  always_comb begin
    w_ctrl  = 4'b0000;
    w_multi = 1'b0;
    w_undef = 1'b0;
    w_load  = '0;
    unique case (bus.alu_op)
      2'b00: w_ctrl = 4'b0010;
      2'b01: w_ctrl = 4'b0110;
      2'b11: w_ctrl = 4'b0000;
      default: begin
        case (bus.funct)
          6'b100100: w_ctrl = 4'b0000;
          6'b100101: w_ctrl = 4'b0001;
          6'b100000: w_ctrl = 4'b0010;
          6'b100010: w_ctrl = 4'b0110;
          6'b100111: w_ctrl = 4'b1100;
          6'b100110: w_ctrl = 4'b0100;
          6'b101010: w_ctrl = 4'b0111;
          6'b000000: w_ctrl = 4'b1000;
          6'b000010: w_ctrl = 4'b1001;
          6'b000011: w_ctrl = 4'b1010;
          6'b011000: begin
            w_ctrl  = 4'b0101;
            w_multi = 1'b1;
            w_load  = MUL_LOAD;
          end
          6'b011010: begin
            w_ctrl  = 4'b1011;
            w_multi = 1'b1;
            w_load  = DIV_LOAD;
          end
          default: w_undef = 1'b1;
        endcase
      end
    endcase
  end

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  assign w_illegal_set = w_undef;
`else
  // Undefined funct is an ordinary single-cycle 0000 op; flag never raised.
  logic w_unused_undef;
  assign w_unused_undef = w_undef;
  assign w_illegal_set  = 1'b0;
`endif

  assign w_busy   = (r_state == ST_MULTI);
  assign w_accept = bus.in_valid && !w_busy && !bus.flush;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_ctrl      <= 4'b0000;
      r_out_valid <= 1'b0;
      r_multi     <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (bus.flush) begin
      // Kill in-flight op and drop any simultaneous request; alu_ctrl keeps its last value.
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_multi     <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (w_accept) begin
        r_ctrl    <= w_ctrl;
        r_multi   <= w_multi;
        r_illegal <= w_illegal_set;
        if (w_multi) begin
          r_state <= ST_MULTI;
          r_cnt   <= w_load;
        end else begin
          r_out_valid <= 1'b1;
        end
      end else if (r_state == ST_MULTI) begin
        // Counter at 1 means this edge enters the final (result) cycle.
        if (r_cnt == CNT_W'(1)) begin
          r_state     <= ST_IDLE;
          r_cnt       <= '0;
          r_out_valid <= 1'b1;
        end else begin
          r_cnt <= r_cnt - CNT_W'(1);
        end
      end
    end
  end

  assign bus.in_ready   = !w_busy;
  assign bus.busy       = w_busy;
  assign bus.out_valid  = r_out_valid;
  assign bus.alu_ctrl   = r_ctrl;
  assign bus.multicycle = r_multi;
  assign bus.illegal    = r_illegal;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed self-checking bench for alu_op_sequencer (default parameters).
module tb_alu_op_sequencer;

  logic i_clk;
  logic i_reset;
  int   n_checks;
  int   n_errors;

  alu_op_sequencer_if u_if ();

  alu_op_sequencer u_dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (u_if)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  localparam logic EXP_ILLEGAL = 1'b1;
`else
  localparam logic EXP_ILLEGAL = 1'b0;
`endif

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, req);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] fn);
    u_if.in_valid = v;
    u_if.alu_op   = op;
    u_if.funct    = fn;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, ".alu_ctrl"},   32'(u_if.alu_ctrl),   32'h0);
    check_eq({tag, ".out_valid"},  32'(u_if.out_valid),  32'h0);
    check_eq({tag, ".busy"},       32'(u_if.busy),       32'h0);
    check_eq({tag, ".multicycle"}, 32'(u_if.multicycle), 32'h0);
    check_eq({tag, ".illegal"},    32'(u_if.illegal),    32'h0);
    check_eq({tag, ".in_ready"},   32'(u_if.in_ready),   32'h1);
  endtask

  // R-type single-cycle funct table with hand-decoded controls.
  logic [5:0] tbl_fn [9];
  logic [3:0] tbl_ct [9];

  initial begin
    n_checks = 0;
    n_errors = 0;
    tbl_fn = '{6'b100100, 6'b100101, 6'b100000, 6'b100010, 6'b100111,
               6'b100110, 6'b101010, 6'b000000, 6'b000010};
    tbl_ct = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100,
               4'b0100, 4'b0111, 4'b1000, 4'b1001};

    i_reset = 1'b1;
    u_if.flush = 1'b0;
    drive(1'b0, 2'b00, 6'b000000);
    step();
    step();
    check_reset_state("reset");
    i_reset = 1'b0;

    // Single sub.
    drive(1'b1, 2'b10, 6'b100010);
    step();
    drive(1'b0, 2'b00, 6'b000000);
    check_eq("sub.out_valid",  32'(u_if.out_valid),  32'h1);
    check_eq("sub.alu_ctrl",   32'(u_if.alu_ctrl),   32'h6);
    check_eq("sub.busy",       32'(u_if.busy),       32'h0);
    check_eq("sub.multicycle", 32'(u_if.multicycle), 32'h0);
    step();
    check_eq("sub.pulse_end",  32'(u_if.out_valid),  32'h0);
    check_eq("sub.ctrl_hold",  32'(u_if.alu_ctrl),   32'h6);

    // Back-to-back 00, 11, 10/nor.
    drive(1'b1, 2'b00, 6'b000000);
    step();
    check_eq("b2b0.out_valid", 32'(u_if.out_valid), 32'h1);
    check_eq("b2b0.alu_ctrl",  32'(u_if.alu_ctrl),  32'h2);
    drive(1'b1, 2'b11, 6'b000000);
    step();
    check_eq("b2b1.out_valid", 32'(u_if.out_valid), 32'h1);
    check_eq("b2b1.alu_ctrl",  32'(u_if.alu_ctrl),  32'h0);
    drive(1'b1, 2'b10, 6'b100111);
    step();
    check_eq("b2b2.out_valid", 32'(u_if.out_valid), 32'h1);
    check_eq("b2b2.alu_ctrl",  32'(u_if.alu_ctrl),  32'hc);

    // Rest of the R-type table, also back-to-back; then sra and branch sub.
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 2'b10, tbl_fn[i]);
      step();
      check_eq($sformatf("funct%0d.out_valid", i), 32'(u_if.out_valid), 32'h1);
      check_eq($sformatf("funct%0d.alu_ctrl", i),  32'(u_if.alu_ctrl),  32'(tbl_ct[i]));
    end
    drive(1'b1, 2'b10, 6'b000011);
    step();
    check_eq("sra.alu_ctrl", 32'(u_if.alu_ctrl), 32'ha);
    drive(1'b1, 2'b01, 6'b101010);
    step();
    check_eq("beq.alu_ctrl", 32'(u_if.alu_ctrl), 32'h6);
    drive(1'b0, 2'b00, 6'b000000);
    step();

    // Div with add held on in_valid.
    drive(1'b1, 2'b10, 6'b011010);
    step();
    drive(1'b1, 2'b00, 6'b000000);
    for (int k = 1; k <= 7; k++) begin
      check_eq($sformatf("div.busy@T+%0d", k),       32'(u_if.busy),       32'h1);
      check_eq($sformatf("div.in_ready@T+%0d", k),   32'(u_if.in_ready),   32'h0);
      check_eq($sformatf("div.out_valid@T+%0d", k),  32'(u_if.out_valid),  32'h0);
      check_eq($sformatf("div.alu_ctrl@T+%0d", k),   32'(u_if.alu_ctrl),   32'hb);
      check_eq($sformatf("div.multicycle@T+%0d", k), 32'(u_if.multicycle), 32'h1);
      step();
    end
    check_eq("div.out_valid@T+8", 32'(u_if.out_valid), 32'h1);
    check_eq("div.alu_ctrl@T+8",  32'(u_if.alu_ctrl),  32'hb);
    check_eq("div.busy@T+8",      32'(u_if.busy),      32'h0);
    check_eq("div.in_ready@T+8",  32'(u_if.in_ready),  32'h1);
    step();
    drive(1'b0, 2'b00, 6'b000000);
    check_eq("add_after_div.out_valid",  32'(u_if.out_valid),  32'h1);
    check_eq("add_after_div.alu_ctrl",   32'(u_if.alu_ctrl),   32'h2);
    check_eq("add_after_div.multicycle", 32'(u_if.multicycle), 32'h0);
    step();
    check_eq("add_after_div.pulse_end", 32'(u_if.out_valid), 32'h0);

    // Plain mul latency 3.
    drive(1'b1, 2'b10, 6'b011000);
    step();
    drive(1'b0, 2'b00, 6'b000000);
    check_eq("mul.busy@T+1",      32'(u_if.busy),      32'h1);
    check_eq("mul.out_valid@T+1", 32'(u_if.out_valid), 32'h0);
    step();
    check_eq("mul.busy@T+2",      32'(u_if.busy),      32'h1);
    check_eq("mul.out_valid@T+2", 32'(u_if.out_valid), 32'h0);
    step();
    check_eq("mul.out_valid@T+3", 32'(u_if.out_valid), 32'h1);
    check_eq("mul.alu_ctrl@T+3",  32'(u_if.alu_ctrl),  32'h5);
    check_eq("mul.busy@T+3",      32'(u_if.busy),      32'h0);
    step();

    // Mul killed by flush at T+1 with a request presented alongside.
    drive(1'b1, 2'b10, 6'b011000);
    step();
    check_eq("mflush.busy@T+1", 32'(u_if.busy), 32'h1);
    u_if.flush = 1'b1;
    drive(1'b1, 2'b00, 6'b000000);
    step();
    u_if.flush = 1'b0;
    drive(1'b0, 2'b00, 6'b000000);
    check_eq("mflush.busy@T+2",       32'(u_if.busy),       32'h0);
    check_eq("mflush.in_ready@T+2",   32'(u_if.in_ready),   32'h1);
    check_eq("mflush.multicycle@T+2", 32'(u_if.multicycle), 32'h0);
    check_eq("mflush.out_valid@T+2",  32'(u_if.out_valid),  32'h0);
    for (int k = 3; k <= 5; k++) begin
      step();
      check_eq($sformatf("mflush.out_valid@T+%0d", k), 32'(u_if.out_valid), 32'h0);
    end

    // Flush while idle drops the request.
    u_if.flush = 1'b1;
    drive(1'b1, 2'b01, 6'b000000);
    step();
    u_if.flush = 1'b0;
    drive(1'b0, 2'b00, 6'b000000);
    check_eq("iflush.out_valid", 32'(u_if.out_valid), 32'h0);

    // Reset at T+2 of a mul.
    drive(1'b1, 2'b10, 6'b011000);
    step();
    drive(1'b0, 2'b00, 6'b000000);
    step();
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    check_reset_state("midreset");
    step();
    check_eq("midreset.no_resume", 32'(u_if.out_valid), 32'h0);

    // Undefined funct.
    drive(1'b1, 2'b10, 6'b111111);
    step();
    drive(1'b1, 2'b00, 6'b000000);
    check_eq("undef.out_valid", 32'(u_if.out_valid), 32'h1);
    check_eq("undef.alu_ctrl",  32'(u_if.alu_ctrl),  32'h0);
    check_eq("undef.illegal",   32'(u_if.illegal),   32'(EXP_ILLEGAL));
    step();
    drive(1'b0, 2'b00, 6'b000000);
    check_eq("undef_next.illegal",  32'(u_if.illegal),  32'h0);
    check_eq("undef_next.alu_ctrl", 32'(u_if.alu_ctrl), 32'h2);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
